// File: rtl/key_loader_pkg.sv
// Shared types and CRC constants for the serial key loader.
package key_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ACTIVE,
    ST_LOCKOUT
  } state_t;

  localparam int             CRC_W    = 8;
  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
  localparam logic [CRC_W-1:0] CRC_INIT = 8'h00;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB-first, unreflected) over the key bits of a frame.
module crc8_serial
  import key_loader_pkg::*;
(
  input  logic             CK,
  input  logic             RST,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] r_crc;
  logic             w_fb;

  assign w_fb  = i_bit ^ r_crc[CRC_W-1];
  assign o_crc = r_crc;

  always_ff @(posedge CK) begin
    if (RST || i_clear)
      r_crc <= CRC_INIT;
    else if (i_en)
      r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
  end

endmodule

// File: rtl/key_loader.sv
// Serial key provisioning: receives key + CRC-8, commits the key on a match,
// gates the locked core until then, and locks out after repeated failures.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_WIDTH = 2,
  parameter int MAX_FAIL  = 3
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 key_start,
  input  logic                 key_sdi,
  input  logic                 key_valid,
  output logic                 key_ready,
  output logic [KEY_WIDTH-1:0] keyinput,
  output logic                 core_en,
  output logic                 key_ok,
  output logic                 key_err,
  output logic                 lockout
);

  localparam int FRAME  = KEY_WIDTH + CRC_W;
  localparam int CNT_W  = $clog2(FRAME + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0]  KEY_BITS = CNT_W'(KEY_WIDTH);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [KEY_WIDTH-1:0] r_shadow, w_shadow_nxt, r_key;
  logic [CRC_W-1:0]     r_rx, w_crc;
  logic [FAIL_W-1:0]    r_fail, w_fail_inc;
  logic                 r_err;
  logic                 w_start, w_xfer, w_key_phase, w_last, w_match;

  assign w_start     = (r_state == ST_IDLE) && key_start;
  assign w_xfer      = (r_state == ST_LOAD) && key_valid;
  assign w_key_phase = r_bit_cnt < KEY_BITS;
  assign w_last      = w_xfer && (r_bit_cnt == LAST_BIT);
  assign w_match     = (w_crc == r_rx);
  assign w_fail_inc  = (r_fail == FAIL_MAX) ? r_fail : r_fail + FAIL_W'(1);

  crc8_serial u_crc (
    .CK      (CK),
    .RST     (RST),
    .i_clear (w_start),
    .i_en    (w_xfer && w_key_phase),
    .i_bit   (key_sdi),
    .o_crc   (w_crc)
  );

  always_ff @(posedge CK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (key_start) w_next = ST_LOAD;
      ST_LOAD:  if (w_last)    w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_match)                    w_next = ST_ACTIVE;
        else if (w_fail_inc == FAIL_MAX) w_next = ST_LOCKOUT;
        else                            w_next = ST_IDLE;
      end
      ST_ACTIVE:  w_next = ST_ACTIVE;
      ST_LOCKOUT: w_next = ST_LOCKOUT;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Key bit 0 arrives first, so shift in from the top and it lands at bit 0.
  always_comb begin
    w_shadow_nxt                = r_shadow >> 1;
    w_shadow_nxt[KEY_WIDTH-1]   = key_sdi;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_bit_cnt <= '0;
      r_shadow  <= '0;
      r_rx      <= '0;
      r_key     <= '0;
      r_fail    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= '0;
        r_shadow  <= '0;
        r_rx      <= '0;
      end
      if (w_xfer) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        if (w_key_phase) r_shadow <= w_shadow_nxt;
        else             r_rx     <= {r_rx[CRC_W-2:0], key_sdi};
      end
      if (r_state == ST_CHECK) begin
        if (w_match) begin
          r_key  <= r_shadow;
          r_fail <= '0;
        end else begin
          r_fail <= w_fail_inc;
          r_err  <= 1'b1;
        end
      end
      if (r_state == ST_LOCKOUT) r_key <= '0;
    end
  end

  assign key_ready = (r_state == ST_LOAD);
  assign key_ok    = (r_state == ST_ACTIVE);
  assign core_en   = (r_state == ST_ACTIVE);
  assign lockout   = (r_state == ST_LOCKOUT);
  assign keyinput  = r_key;
  assign key_err   = r_err;

endmodule

// File: tb/tb_key_loader.sv
// Randomized self-checking bench for key_loader against a frame-level model.
module tb_key_loader;

  localparam int KW    = 2;
  localparam int MF    = 3;
  localparam int FRAME = KW + 8;

  logic          CK = 1'b0;
  logic          RST = 1'b1;
  logic          key_start = 1'b0, key_sdi = 1'b0, key_valid = 1'b0;
  logic          key_ready, core_en, key_ok, key_err, lockout;
  logic [KW-1:0] keyinput;

  int n_chk = 0, n_fail = 0;

  // model: outcome-level view of the loader
  bit            m_active, m_lock;
  int            m_fail;
  logic [KW-1:0] m_key;

  key_loader #(.KEY_WIDTH(KW), .MAX_FAIL(MF)) dut (
    .CK(CK), .RST(RST), .key_start(key_start), .key_sdi(key_sdi),
    .key_valid(key_valid), .key_ready(key_ready), .keyinput(keyinput),
    .core_en(core_en), .key_ok(key_ok), .key_err(key_err), .lockout(lockout)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // CRC as remainder of M(x)*x^8 mod (x^8+x^2+x+1), key bit 0 as highest-order term.
  function automatic logic [7:0] crc_ref(input logic [KW-1:0] k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < KW; i++) r[KW - 1 - i + 8] = k[i];
    for (int j = KW + 7; j >= 8; j--)
      if (r[j]) r = r ^ (64'h107 << (j - 8));
    return r[7:0];
  endfunction

  task automatic tick();
    @(posedge CK); #1;
  endtask

  task automatic chk_outs(input string tag, input logic exp_err);
    logic [KW-1:0] ek;
    ek = m_active ? m_key : '0;
    chk({tag, "_key"},  keyinput, ek);
    chk({tag, "_ok"},   key_ok,   m_active);
    chk({tag, "_en"},   core_en,  m_active);
    chk({tag, "_lock"}, lockout,  m_lock);
    chk({tag, "_err"},  key_err,  exp_err);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    for (int c = 0; c < 2; c++) begin
      key_start = 1'($urandom); key_valid = 1'($urandom); key_sdi = 1'($urandom);
      tick();
    end
    RST = 1'b0; key_start = 1'b0; key_valid = 1'b0;
    m_active = 0; m_lock = 0; m_fail = 0; m_key = '0;
    chk_outs("rst", 1'b0);
    chk("rst_ready", key_ready, 1'b0);
  endtask

  task automatic send(input logic [KW-1:0] k, input logic [7:0] c, input int stall_pct,
                      input int nbits, input bit valid_with_start);
    bit            loading, exp_err;
    logic [FRAME-1:0] fb;
    int            stalls;
    loading = !m_active && !m_lock;
    for (int i = 0; i < FRAME; i++) fb[i] = (i < KW) ? k[i] : c[7 - (i - KW)];
    key_start = 1'b1; key_valid = valid_with_start; key_sdi = 1'($urandom);
    tick();
    key_start = 1'b0; key_valid = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      stalls = 0;
      while (stalls < 6 && $urandom_range(99) < stall_pct) begin
        chk("ready_stall", key_ready, loading);
        key_sdi = 1'($urandom);
        tick();
        stalls++;
      end
      chk("ready", key_ready, loading);
      key_valid = 1'b1; key_sdi = fb[i];
      tick();
      key_valid = 1'b0; key_sdi = 1'($urandom);
    end
    if (nbits < FRAME) return;
    // CHECK cycle: nothing visible yet
    chk("chk_ready", key_ready, 1'b0);
    chk_outs("chk", 1'b0);
    exp_err = 1'b0;
    if (loading) begin
      if (c == crc_ref(k)) begin
        m_active = 1; m_key = k; m_fail = 0;
      end else begin
        m_fail++; exp_err = 1'b1;
        if (m_fail >= MF) m_lock = 1;
      end
    end
    tick();
    chk_outs("res", exp_err);
    tick();
    chk_outs("post", 1'b0);
    chk("post_ready", key_ready, 1'b0);
  endtask

  initial begin
    logic [KW-1:0] rk;
    logic [7:0]    rc;
    do_reset();

    // good load, back to back; later start ignored
    send(2'b01, 8'h0E, 0, FRAME, 1'b0);
    send(2'b10, 8'h07, 0, FRAME, 1'b0);

    // good load with stalls, start+valid in the same cycle
    do_reset();
    send(2'b10, 8'h07, 50, FRAME, 1'b1);

    // bad then good
    do_reset();
    send(2'b01, 8'h00, 0, FRAME, 1'b0);
    send(2'b01, 8'h0E, 20, FRAME, 1'b0);

    // lockout
    do_reset();
    send(2'b01, 8'h00, 0, FRAME, 1'b0);
    send(2'b11, 8'h55, 30, FRAME, 1'b0);
    send(2'b10, 8'h00, 0, FRAME, 1'b0);
    send(2'b01, 8'h0E, 0, FRAME, 1'b0);
    do_reset();
    send(2'b11, crc_ref(2'b11), 0, FRAME, 1'b0);

    // reset mid-load
    do_reset();
    send(2'b11, crc_ref(2'b11), 0, 5, 1'b0);
    do_reset();
    send(2'b10, 8'h07, 0, FRAME, 1'b0);

    // randomized
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(3) == 0) do_reset();
      rk = KW'($urandom);
      rc = $urandom_range(1) ? crc_ref(rk) : 8'($urandom);
      send(rk, rc, $urandom_range(60), FRAME, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_loader.md
# key_loader

Serial key-provisioning front end for the locked benchmark cores. It receives the unlock key bit-serially with a CRC-8 check and commits it to a held `keyinput` bus only after the check passes. It also gates the locked core's state elements through `core_en` until a valid key is present, and locks out permanently (until reset) after repeated bad loads. It sits between the key-delivery path (tamper-proof store or tester) and the `keyinput` port of an obfuscated core.

## Interface
- `KEY_WIDTH`, default 2: width of the key bus driven to the locked core (1..64).
- `MAX_FAIL`, default 3: consecutive CRC failures that force lockout (≥1).
- `CK`  in  1: single clock, rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `key_start`  in  1: one-cycle request to begin a load.
- `key_sdi`  in  1: serial data bit.
- `key_valid`  in  1: `key_sdi` valid this cycle.
- `key_ready`  out  1: block accepts a bit this cycle.
- `keyinput`  out  KEY_WIDTH: committed key to the locked core.
- `core_en`  out  1: enable for the locked core's flops.
- `key_ok`  out  1: a valid key is committed.
- `key_err`  out  1: one-cycle pulse on CRC mismatch.
- `lockout`  out  1: terminal failure state.

## Operation
- FSM states: IDLE, LOAD, CHECK, ACTIVE, LOCKOUT.
- IDLE: `key_start`=1 moves to LOAD; the bit counter and CRC are cleared to 0.
- LOAD: `key_ready`=1. A bit transfers on any cycle with `key_valid && key_ready`.
  - Frame is KEY_WIDTH key bits (key bit 0 first), then 8 CRC bits (CRC bit 7 first).
  - Key bits are shifted into a shadow register and fed to the CRC engine.
  - CRC bits are shifted into a receive register.
  - After the last CRC bit transfers, the FSM moves to CHECK.
- CRC-8: polynomial 0x07 (x^8+x^2+x+1), init 0x00, no reflection, no final XOR.
  - Per key bit: `fb = bit ^ crc[7]`; `crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00)`.
- CHECK (one cycle): compare the computed CRC against the received CRC.
  - Match: `keyinput` ← shadow, fail counter ← 0, FSM → ACTIVE.
  - Mismatch: fail counter +1 and `key_err` pulses. The FSM moves to LOCKOUT if the new count equals MAX_FAIL, otherwise to IDLE.
- ACTIVE: `key_ok`=1, `core_en`=1. The key is write-once per reset, so `key_start` is ignored.
- LOCKOUT: `lockout`=1, `core_en`=0, `keyinput` held at 0. All inputs are ignored; only `RST` exits.
- Ignored inputs:
  - `key_start` outside IDLE.
  - `key_valid` outside LOAD.
- `keyinput` never shows partial shadow contents.
- Fail-counter width is $clog2(MAX_FAIL+1). The counter saturates and never wraps.

## Timing
- On a cycle with `RST`=1, the next state is:
  - IDLE, with `keyinput`=0, `core_en`=0, `key_ok`=0, `key_err`=0, `lockout`=0, `key_ready`=0.
  - Fail counter, bit counter, CRC, shadow and receive registers all 0.
- `RST` during any state, including mid-LOAD or LOCKOUT, aborts with no commit.
- All outputs are registered or are decodes of the registered state.
- `key_start` at edge t: `key_ready`=1 from cycle t+1.
- The last bit transfers at edge t: CHECK occupies cycle t+1.
  - On a match, `keyinput`, `key_ok` and `core_en` change from cycle t+2.
  - On a mismatch, `key_err`=1 for cycle t+2 only, together with IDLE or LOCKOUT.
- Throughput: one bit per cycle. Stalls (`key_valid`=0) are unlimited, and there is no timeout.
- `key_start` and `key_valid` asserted in the same cycle in IDLE: only the start takes effect, and that bit is not consumed.

## Structure
- Package `key_loader_pkg` contains:
  - the state enum;
  - `CRC_W`=8;
  - `CRC_POLY`=8'h07;
  - `CRC_INIT`=8'h00.
- Sub-module `crc8_serial` has inputs clear, enable and bit, and outputs the crc value. The top holds the FSM, counters, shadow and receive registers, and the commit register.

## Test plan
- Reset: hold `RST` for 2 cycles with random inputs → all outputs 0, state IDLE.
- Good load, KEY_WIDTH=2, key=2'b01: bits 1,0 then CRC 0x0E, back-to-back.
  - `keyinput`=2'b01, `key_ok`=`core_en`=1 exactly two cycles after the last bit.
  - A later `key_start` leaves the state unchanged.
- Good load with stalls: key=2'b10, CRC 0x07, random `key_valid` gaps → `keyinput`=2'b10, and `key_ready` stays high throughout LOAD.
- Bad CRC: key=2'b01 with CRC 0x00.
  - One `key_err` pulse, return to IDLE, `keyinput` still 0.
  - A following good load succeeds and clears the fail count.
- Lockout: three consecutive bad loads, MAX_FAIL=3.
  - `lockout`=1 after the third load, and a subsequent good load is ignored.
  - `RST` restores IDLE, and a good load then succeeds.
- Reset mid-LOAD: apply `RST` after 5 of 10 bits → IDLE, no commit, and the next full load works.
